fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage. Produces the IF/ID pipeline register that feeds the decode stage: currInstruct and plusTwoPC.
- Consumes the decode-stage jump resolution (redirect/redirectPC) and the hazard stall.
- Talks to a variable-latency instruction memory through a req/done handshake.
- Owns the PC, wrong-path squash, a one-entry hold buffer, and halt detection.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, bubble instruction (opcode 00001) placed in IF/ID when invalid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; rst==0 at a posedge resets the block.
- stall  in  1  hazard unit: hold IF/ID contents.
- redirect  in  1  decode-stage jumpDTaken.
- redirectPC  in  16  decode-stage jumpDDest.
- imemReq  out  1  fetch request; address valid.
- imemAddr  out  16  fetch address (the current pc).
- imemDone  in  1  response valid; may assert the same cycle as imemReq or any later cycle.
- imemData  in  16  instruction word, valid when imemDone=1.
- currInstruct  out  16  IF/ID instruction.
- plusTwoPC  out  16  IF/ID fetched PC + 2.
- instrValid  out  1  IF/ID holds a real instruction.
- halted  out  1  halt fetched; stage idle.
- err  out  1  sticky error (see Optional Feature).

Behaviour:
- Reset (rst==0 at posedge): pc=RESET_PC, state=FETCH, currInstruct=NOP_INSTR, plusTwoPC=16'h0000, instrValid=0, bufValid=0, halted=0, err=0. While rst==0: imemReq=0.
- imemAddr=pc always. imemReq = (state==FETCH) & ~redirect & ~bufValid.
- States: FETCH, WAIT, DROP, HALT. The halted output is 1 exactly in HALT.
- FETCH:
  - req & done in the same cycle: response completes this edge, stay in FETCH. Sustained throughput is 1 instruction/cycle.
  - req & ~done: go to WAIT.
- WAIT:
  - done: response completes, go to FETCH.
  - redirect & ~done: pc<=redirectPC, go to DROP.
- DROP: waits for the stale response. On done, discard imemData and go to FETCH. Further redirects while in DROP update pc only.
- Response completion:
  - ~stall: IF/ID <= {imemData, pc+2, valid=1}.
  - stall: hold buffer <= {imemData, pc+2}, bufValid<=1.
  - In both cases pc<=pc+2.
  - If imemData[15:11]==5'b00000 (HALT), next state is HALT instead of FETCH.
- Hold buffer: when bufValid & ~stall, IF/ID <= buffer and bufValid<=0. No new request issues while bufValid=1.
- Stall with no buffer drain: IF/ID unchanged, including instrValid.
- Redirect (highest priority, overrides stall, done and halt detection):
  - pc<=redirectPC.
  - IF/ID <= {NOP_INSTR, 16'h0000, valid=0}; bufValid<=0.
  - A response arriving the same cycle is discarded. From FETCH/HALT go to FETCH; from WAIT go to DROP.
- HALT: no requests; IF/ID still drains/holds normally. A redirect leaves HALT (the halt was wrong-path) and clears halted.
- Arithmetic: pc+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000. redirectPC is used unmodified.
- rst==0 mid-WAIT: the in-flight response is abandoned; memory must tolerate a dropped request.

Optional Feature:
- FETCH_ERR_CHECK_EN defined: err is set (sticky until reset) on either of:
  - redirect with redirectPC[0]==1;
  - imemDone with any X/Z bit on imemData (^imemData === 1'bx or 1'bz).
- Undefined: err tied to 0; no checking logic.

Decomposition:
- Package fetch_pkg: state enum (FETCH, WAIT, DROP, HALT), OPC_HALT=5'b00000, default NOP_INSTR value.
- One sub-module: fetch_holdbuf, the one-entry instruction/PC hold buffer with load/drain/flush controls.
- PC, FSM and IF/ID register stay in fetch_stage.

Test Plan:
- Zero-latency memory (done same cycle as req), program 16'h4000,16'h4100 at 0,2 -> IF/ID shows 4000/plusTwoPC 0002, then 4100/0004 on consecutive cycles; instrValid=1.
- Two-cycle latency, redirect to 16'h0040 while in WAIT -> stale data dropped. Next imemAddr=0040; IF/ID gets the word at 0040 with plusTwoPC 0042; instrValid=0 in between.
- stall=1 for 3 cycles while a response arrives -> IF/ID unchanged; bufValid=1; no imemReq. On release, the buffered word enters IF/ID the next edge and fetching resumes at pc+2.
- Fetch 16'h0000 (HALT) at 0x0010 -> halted=1, imemReq stays 0. Then redirect to 0x0100 -> halted=0, imemAddr=0100.
- Redirect to 16'hFFFE, sequential fetch -> next imemAddr 16'h0000 (wrap). rst=0 during WAIT -> all outputs at reset values next edge; restart at RESET_PC.
- With FETCH_ERR_CHECK_EN: redirectPC=16'h0003 -> err=1 and stays 1 until reset. Without the macro: err=0 for the same stimulus.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 5;

  localparam logic [OPC_W-1:0]   OPC_HALT    = 5'b00000;
  localparam logic [INSTR_W-1:0] DEFAULT_NOP = 16'h0800;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    HALT  = 2'd3
  } fetchState_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    plusTwo;
  } ifidEntry_t;

  function automatic logic isHaltOp(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_holdbuf.sv
// One-entry instruction/PC hold buffer: catches a response that lands during a stall.
module fetch_holdbuf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       drain,
  input  logic       flush,
  input  ifidEntry_t loadEntry,
  output logic       bufValid,
  output ifidEntry_t bufEntry
);

  // Flush wins over load so a wrong-path response never survives a redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bufValid <= 1'b0;
      bufEntry <= '0;
    end else if (flush) begin
      bufValid <= 1'b0;
    end else if (load) begin
      bufValid <= 1'b1;
      bufEntry <= loadEntry;
    end else if (drain) begin
      bufValid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, memory handshake FSM, wrong-path squash and IF/ID register.
// Optional fetch error checking is enabled by defining FETCH_ERR_CHECK_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirectPC,
  output logic               imemReq,
  output logic [PC_W-1:0]    imemAddr,
  input  logic               imemDone,
  input  logic [INSTR_W-1:0] imemData,
  output logic [INSTR_W-1:0] currInstruct,
  output logic [PC_W-1:0]    plusTwoPC,
  output logic               instrValid,
  output logic               halted,
  output logic               err
);

  fetchState_t       state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pcPlusTwo;
  logic              bufValid;
  ifidEntry_t        bufEntry;
  ifidEntry_t        respEntry;
  logic              reqActive;
  logic              complete;
  logic              bufLoad;
  logic              bufDrain;

  assign pcPlusTwo = pc + PC_W'(2);
  assign reqActive = (state == FETCH) && !redirect && !bufValid;
  assign imemReq   = rst && reqActive;
  assign imemAddr  = pc;
  assign halted    = (state == HALT);

  // A response is accepted only for a live request; redirect discards it.
  assign complete  = imemDone && !redirect &&
                     (((state == FETCH) && !bufValid) || (state == WAIT));
  assign respEntry = '{instr: imemData, plusTwo: pcPlusTwo};
  assign bufLoad   = complete && stall;
  assign bufDrain  = bufValid && !stall && !redirect;

  fetch_holdbuf u_holdbuf (
    .clk       (clk),
    .rst       (rst),
    .load      (bufLoad),
    .drain     (bufDrain),
    .flush     (redirect),
    .loadEntry (respEntry),
    .bufValid  (bufValid),
    .bufEntry  (bufEntry)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      currInstruct <= NOP_INSTR;
      plusTwoPC    <= '0;
      instrValid   <= 1'b0;
    end else if (redirect) begin
      // An outstanding request with no response yet must be drained in DROP.
      pc           <= redirectPC;
      currInstruct <= NOP_INSTR;
      plusTwoPC    <= '0;
      instrValid   <= 1'b0;
      state        <= (((state == WAIT) || (state == DROP)) && !imemDone) ? DROP : FETCH;
    end else begin
      if (complete) begin
        pc    <= pcPlusTwo;
        state <= isHaltOp(imemData) ? HALT : FETCH;
      end else if ((state == FETCH) && reqActive) begin
        state <= WAIT;
      end else if ((state == DROP) && imemDone) begin
        state <= FETCH;
      end

      if (!stall) begin
        if (complete) begin
          currInstruct <= imemData;
          plusTwoPC    <= pcPlusTwo;
          instrValid   <= 1'b1;
        end else if (bufValid) begin
          currInstruct <= bufEntry.instr;
          plusTwoPC    <= bufEntry.plusTwo;
          instrValid   <= 1'b1;
        end else begin
          currInstruct <= NOP_INSTR;
          plusTwoPC    <= '0;
          instrValid   <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_ERR_CHECK_EN
  logic errQ;
  logic dataUnknown;

  assign dataUnknown = ((^imemData) === 1'bx) || ((^imemData) === 1'bz);

  // Sticky until reset: misaligned jump target or undriven instruction bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      errQ <= 1'b0;
    end else if ((redirect && redirectPC[0]) || (imemDone && dataUnknown)) begin
      errQ <= 1'b1;
    end
  end

  assign err = errQ;
`else
  assign err = 1'b0;
`endif

endmodule
